// File: rtl/spi_pkg.sv
// Shared SPI target definitions: FSM states, default idle byte, CRC7 polynomial and step.
package spi_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;
  localparam logic [6:0] CRC7_POLY         = 7'h09;

  // One serial step of CRC7 (x^7+x^3+1), MSB-first input.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    crc7_next = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop pin synchroniser with selectable reset level.
// Latency STAGES CLK cycles; no flow control.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, rx/tx byte streams with one holding register each.
// Rx byte valid SYNC_STAGES+1 cycles after 8th sclk rise; rx full drops bytes (overrun), tx empty sends IDLE_BYTE. CRC7 under SPI_TARGET_CRC7_EN.
module spi_target
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       spi_miso_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic [6:0] crc7
);

  logic       clk_sync, mosi_sync, cs_sync, clk_prev;
  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, tx_hold, rx_byte, tx_next;
  logic       tx_full;
  logic       rise, fall, enter, leave, act, load, done, consume, capture;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk
    (.CLK(CLK), .RST_N(RST_N), .d(spi_clk),  .q(clk_sync));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi
    (.CLK(CLK), .RST_N(RST_N), .d(spi_mosi), .q(mosi_sync));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs
    (.CLK(CLK), .RST_N(RST_N), .d(spi_cs),   .q(cs_sync));

  always_comb begin
    rise    = clk_sync & ~clk_prev;
    fall    = ~clk_sync & clk_prev;
    enter   = (state == ST_IDLE) & ~cs_sync;
    leave   = (state == ST_ACTIVE) & cs_sync;
    // A cs edge masks any clock edge seen in the same cycle.
    act     = (state == ST_ACTIVE) & ~cs_sync;
    load    = enter | (act & fall & (bit_cnt == 3'd0));
    done    = act & rise & (bit_cnt == 3'd7);
    consume = rx_valid & rx_ready;
    capture = tx_valid & ~tx_full;
    rx_byte = {rx_shift, mosi_sync};
    tx_next = tx_full ? tx_hold : IDLE_BYTE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_prev <= 1'b0;
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= IDLE_BYTE;
    end else begin
      clk_prev <= clk_sync;
      if (enter) begin
        state    <= ST_ACTIVE;
        bit_cnt  <= 3'd0;
        tx_shift <= tx_next;
      end else if (leave) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
      end else if (act && rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end else if (act && fall) begin
        tx_shift <= (bit_cnt == 3'd0) ? tx_next : {tx_shift[6:0], 1'b0};
      end
    end
  end

  // Capture and load are mutually exclusive: capture needs empty, a taking load needs full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_full <= 1'b0;
      tx_hold <= 8'd0;
    end else if (capture) begin
      tx_full <= 1'b1;
      tx_hold <= tx_data;
    end else if (load) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'd0;
      overrun  <= 1'b0;
    end else begin
      if (done && (!rx_valid || consume)) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_byte;
      end else if (consume) begin
        rx_valid <= 1'b0;
      end
      if (overrun_clr)                         overrun <= 1'b0;
      else if (done && rx_valid && !consume)   overrun <= 1'b1;
    end
  end

`ifdef SPI_TARGET_CRC7_EN
  logic [6:0] crc_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           crc_q <= 7'd0;
    else if (enter)       crc_q <= 7'd0;
    else if (act && rise) crc_q <= crc7_next(crc_q, mosi_sync);
  end
  assign crc7 = crc_q;
`else
  assign crc7 = 7'd0;
`endif

  assign spi_miso    = (state == ST_ACTIVE) ? tx_shift[7] : 1'b1;
  assign spi_miso_en = (state == ST_ACTIVE);
  assign tx_ready    = ~tx_full;

endmodule

// File: tb/tb_spi_target.sv
// Randomized mode-0 master against spi_target with a byte-level reference model.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
  logic       spi_miso, spi_miso_en, rx_valid, rx_ready = 1'b1;
  logic [7:0] rx_data, tx_data = 8'd0;
  logic       tx_valid = 1'b0, tx_ready, overrun, overrun_clr = 1'b0;
  logic [6:0] crc7;

  int n_cmp = 0, n_bad = 0, pulses = 0;
  logic [7:0] mtx [8];
  logic [7:0] mrx [8];
  logic [7:0] got [$];
  logic       rv_prev = 1'b0;

  spi_target dut (
    .CLK(clk), .RST_N(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .spi_miso_en(spi_miso_en), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .crc7(crc7)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (rx_valid && !rv_prev) pulses++;
    rv_prev <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode-0 master: 4-cycle phases, mosi changes on fall, miso sampled just before rise.
  task automatic spi_frame(input int nbits);
    for (int i = 0; i < 8; i++) mrx[i] = 8'h00;
    spi_cs   = 1'b0;
    spi_mosi = mtx[0][7];
    cyc(4);
    for (int i = 0; i < nbits; i++) begin
      mrx[i/8][7-(i%8)] = spi_miso;
      spi_clk = 1'b1;
      cyc(4);
      spi_clk = 1'b0;
      if (i + 1 < nbits) spi_mosi = mtx[(i+1)/8][7-((i+1)%8)];
      cyc(4);
    end
    spi_cs = 1'b1;
    cyc(8);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  // CRC7 as polynomial remainder of the message times x^7.
  function automatic logic [6:0] crc_ref(input int nbytes);
    logic [7:0] r;
    logic       b;
    r = 8'd0;
    for (int i = 0; i < nbytes * 8 + 7; i++) begin
      b = (i < nbytes * 8) ? mtx[i/8][7-(i%8)] : 1'b0;
      r = {r[6:0], b};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [6:0] crc_exp(input int nbytes);
`ifdef SPI_TARGET_CRC7_EN
    return crc_ref(nbytes);
`else
    return 7'd0 & crc_ref(nbytes);
`endif
  endfunction

  initial begin
    cyc(3);
    check("rst_miso", spi_miso, 1);
    check("rst_miso_en", spi_miso_en, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_overrun", overrun, 0);
    check("rst_crc7", crc7, 0);
    rst_n = 1'b1;
    cyc(4);

    // Single byte with a queued response.
    queue_tx(8'h3C);
    check("t1_tx_ready_full", tx_ready, 0);
    mtx[0] = 8'hA5;
    got.delete(); pulses = 0;
    spi_cs = 1'b0; cyc(4);
    check("t1_miso_en", spi_miso_en, 1);
    check("t1_tx_ready_after_cs", tx_ready, 1);
    spi_cs = 1'b1; cyc(8);
    spi_frame(8);
    check("t1_rx_count", got.size(), 1);
    if (got.size() > 0) check("t1_rx_byte", got[0], 8'hA5);
    check("t1_pulses", pulses, 1);
    check("t1_miso_byte", mrx[0], 8'hFF);

    queue_tx(8'h3C);
    got.delete();
    spi_frame(8);
    check("t1b_miso_byte", mrx[0], 8'h3C);
    check("t1b_rx_byte", (got.size() > 0) ? got[0] : 8'hxx, 8'hA5);
    check("t1b_tx_ready", tx_ready, 1);

    // Two bytes, nothing queued.
    mtx[0] = 8'h12; mtx[1] = 8'h34;
    got.delete();
    spi_frame(16);
    check("t2_rx_count", got.size(), 2);
    if (got.size() == 2) begin
      check("t2_rx0", got[0], 8'h12);
      check("t2_rx1", got[1], 8'h34);
    end
    check("t2_miso0", mrx[0], 8'hFF);
    check("t2_miso1", mrx[1], 8'hFF);

    // Overrun with consumer stalled.
    rx_ready = 1'b0;
    mtx[0] = 8'h01; mtx[1] = 8'h02;
    spi_frame(16);
    check("t3_rx_valid", rx_valid, 1);
    check("t3_rx_data", rx_data, 8'h01);
    check("t3_overrun", overrun, 1);
    overrun_clr = 1'b1; cyc(1); overrun_clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);
    rx_ready = 1'b1; cyc(2);
    check("t3_drained", rx_valid, 0);

    // Partial frame is discarded.
    got.delete();
    mtx[0] = 8'hF0;
    spi_frame(5);
    check("t4_miso_en_gap", spi_miso_en, 0);
    check("t4_miso_gap", spi_miso, 1);
    mtx[0] = 8'h5A;
    spi_frame(8);
    check("t4_rx_count", got.size(), 1);
    if (got.size() > 0) check("t4_rx_byte", got[0], 8'h5A);

    // Reset mid-byte.
    spi_cs = 1'b0; cyc(4);
    spi_mosi = 1'b1; spi_clk = 1'b1; cyc(4); spi_clk = 1'b0; cyc(4);
    spi_clk = 1'b1; cyc(2);
    queue_tx(8'h77);
    rst_n = 1'b0; #1;
    check("rr_miso", spi_miso, 1);
    check("rr_miso_en", spi_miso_en, 0);
    check("rr_rx_valid", rx_valid, 0);
    check("rr_tx_ready", tx_ready, 1);
    check("rr_overrun", overrun, 0);
    check("rr_crc7", crc7, 0);
    spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    cyc(3); rst_n = 1'b1; cyc(5);
    got.delete();
    mtx[0] = 8'hC3;
    spi_frame(8);
    check("rr_rx_count", got.size(), 1);
    if (got.size() > 0) check("rr_rx_byte", got[0], 8'hC3);
    check("rr_miso_byte", mrx[0], 8'hFF);

    // CMD0 CRC.
    mtx[0] = 8'h40;
    for (int i = 1; i < 5; i++) mtx[i] = 8'h00;
    spi_frame(40);
`ifdef SPI_TARGET_CRC7_EN
    check("cmd0_crc7", crc7, 7'h4A);
`else
    check("cmd0_crc7", crc7, 7'h00);
`endif

    // Randomized frames against the byte-level model.
    for (int t = 0; t < 8; t++) begin
      int n;
      logic pre;
      logic [7:0] txb;
      n   = $urandom_range(1, 3);
      pre = 1'($urandom_range(0, 1));
      txb = 8'($urandom);
      for (int i = 0; i < n; i++) mtx[i] = 8'($urandom);
      if (pre) queue_tx(txb);
      got.delete();
      spi_frame(n * 8);
      check("rnd_rx_count", got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) check("rnd_rx_byte", got[i], mtx[i]);
      check("rnd_miso0", mrx[0], pre ? txb : 8'hFF);
      for (int i = 1; i < n; i++) check("rnd_miso_idle", mrx[i], 8'hFF);
      check("rnd_overrun", overrun, 0);
      check("rnd_tx_ready", tx_ready, 1);
      check("rnd_crc7", crc7, crc_exp(n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
